// File: rtl/dea_stream.sv
// -----------------------------------------------------------------------------
// dea_stream : streaming XOR cipher engine with a programmable key table.
//
// Words are accepted on a valid/ready handshake and XORed with keys that are
// applied round-robin. A frame start (in_sof on an accepted word) latches the
// active key count, mode and direction, and restarts the key index and chain.
// Chained mode also XORs a feedback value, which is the previous ciphertext
// in both directions, so encrypt and decrypt are exact inverses.
//
// Ports:
//   dclk, reset       clock and asynchronous active-high reset
//   kset/kaddr/kdata  key table write port (a write stalls the data input)
//   num_keys          active key count, clamped to MAX_KEYS (0 = bypass)
//   mode, dir         0 = rolling XOR / 1 = chained; chained 0 = enc, 1 = dec
//   in_valid, in_sof, din, in_ready   input stream
//   out_valid, dout, out_ready        output stream (registered result)
// -----------------------------------------------------------------------------
module dea_stream #(
    parameter int DATA_W   = 8,
    parameter int MAX_KEYS = 4,
    parameter int KW       = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1
) (
    input  logic              dclk,
    input  logic              reset,
    input  logic              kset,
    input  logic [KW-1:0]     kaddr,
    input  logic [DATA_W-1:0] kdata,
    input  logic [KW:0]       num_keys,
    input  logic              mode,
    input  logic              dir,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] din,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] dout,
    input  logic              out_ready
);

    localparam logic [KW:0] MAXK = MAX_KEYS[KW:0];

    logic [DATA_W-1:0] key_q [MAX_KEYS];
    logic [KW-1:0]     idx_q,      idx_d;
    logic [DATA_W-1:0] chain_q,    chain_d;
    logic [KW:0]       cfg_n_q,    cfg_n_d;
    logic              cfg_mode_q, cfg_mode_d;
    logic              cfg_dir_q,  cfg_dir_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] dout_q,     dout_d;

    logic              acc_s;
    logic              key_we_s;
    logic [KW-1:0]     idx_eff_s;
    logic [DATA_W-1:0] chain_eff_s;
    logic [DATA_W-1:0] key_s;
    logic [DATA_W-1:0] res_s;

    // Ready is purely a function of the stall sources, never of in_valid.
    assign in_ready  = ~kset & (~out_valid_q | out_ready);
    assign acc_s     = in_valid & in_ready;
    assign key_we_s  = kset & ({1'b0, kaddr} < MAXK);
    assign out_valid = out_valid_q;
    assign dout      = dout_q;

    // Effective per-word configuration: a frame start applies its new cfg,
    // index 0 and chain 0 to the word that carries in_sof.
    always_comb begin
        cfg_n_d     = cfg_n_q;
        cfg_mode_d  = cfg_mode_q;
        cfg_dir_d   = cfg_dir_q;
        idx_eff_s   = idx_q;
        chain_eff_s = chain_q;
        if (acc_s && in_sof) begin
            cfg_n_d     = (num_keys > MAXK) ? MAXK : num_keys;
            cfg_mode_d  = mode;
            cfg_dir_d   = dir;
            idx_eff_s   = {KW{1'b0}};
            chain_eff_s = {DATA_W{1'b0}};
        end else begin
            cfg_n_d     = cfg_n_q;
        end
    end

    assign key_s = key_q[idx_eff_s];

    // Result word, next key index and next chain value for an accepted word.
    always_comb begin
        res_s   = din;
        idx_d   = idx_q;
        chain_d = chain_q;
        if (acc_s) begin
            if (cfg_n_d == {(KW+1){1'b0}}) begin
                // Bypass: data passes untouched, index and chain only follow
                // the frame-start restart.
                res_s   = din;
                idx_d   = idx_eff_s;
                chain_d = chain_eff_s;
            end else begin
                if (cfg_mode_d == 1'b0) begin
                    res_s   = din ^ key_s;
                    chain_d = chain_eff_s;
                end else begin
                    res_s   = din ^ key_s ^ chain_eff_s;
                    // Feedback is always the ciphertext side of the word.
                    chain_d = (cfg_dir_d == 1'b0) ? res_s : din;
                end
                if ({1'b0, idx_eff_s} == (cfg_n_d - {{KW{1'b0}}, 1'b1})) begin
                    idx_d = {KW{1'b0}};
                end else begin
                    idx_d = idx_eff_s + {{(KW-1){1'b0}}, 1'b1};
                end
            end
        end else begin
            res_s = din;
        end
    end

    // Output register: load on accept, clear on drain, hold under backpressure.
    always_comb begin
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        if (acc_s) begin
            out_valid_d = 1'b1;
            dout_d      = res_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Datapath and configuration state.
    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            idx_q       <= {KW{1'b0}};
            chain_q     <= {DATA_W{1'b0}};
            cfg_n_q     <= {(KW+1){1'b0}};
            cfg_mode_q  <= 1'b0;
            cfg_dir_q   <= 1'b0;
            out_valid_q <= 1'b0;
            dout_q      <= {DATA_W{1'b0}};
        end else begin
            idx_q       <= idx_d;
            chain_q     <= chain_d;
            cfg_n_q     <= cfg_n_d;
            cfg_mode_q  <= cfg_mode_d;
            cfg_dir_q   <= cfg_dir_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
        end
    end

    // Key table; out-of-range addresses are dropped.
    always_ff @(posedge dclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_KEYS; i++) begin
                key_q[i] <= {DATA_W{1'b0}};
            end
        end else if (key_we_s) begin
            key_q[kaddr] <= kdata;
        end
    end

endmodule

// File: tb/tb_dea_stream.sv
module tb_dea_stream;

    logic       dclk = 1'b0;
    logic       reset = 1'b1;
    logic       kset = 1'b0;
    logic [1:0] kaddr = 2'd0;
    logic [7:0] kdata = 8'h00;
    logic [2:0] num_keys = 3'd0;
    logic       mode = 1'b0;
    logic       dir = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] din = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] dout;
    logic       out_ready = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    dea_stream #(.DATA_W(8), .MAX_KEYS(4)) dut (
        .dclk(dclk), .reset(reset), .kset(kset), .kaddr(kaddr), .kdata(kdata),
        .num_keys(num_keys), .mode(mode), .dir(dir), .in_valid(in_valid),
        .in_sof(in_sof), .din(din), .in_ready(in_ready), .out_valid(out_valid),
        .dout(dout), .out_ready(out_ready)
    );

    always #5 dclk = ~dclk;

    typedef struct {
        logic       sof;
        logic [7:0] din;
        logic [2:0] nk;
        logic       mode;
        logic       dir;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic load_key(input logic [1:0] a, input logic [7:0] d);
        in_valid = 1'b0;
        kset  = 1'b1;
        kaddr = a;
        kdata = d;
        tick();
        kset = 1'b0;
    endtask

    task automatic apply(input int i);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_sof    = tbl[i].sof;
        din       = tbl[i].din;
        num_keys  = tbl[i].nk;
        mode      = tbl[i].mode;
        dir       = tbl[i].dir;
        #1;
        chk($sformatf("vec%0d in_ready", i), {7'd0, in_ready}, 8'd1);
        tick();
        chk($sformatf("vec%0d out_valid", i), {7'd0, out_valid}, 8'd1);
        chk($sformatf("vec%0d dout", i), dout, tbl[i].exp);
    endtask

    initial begin
        // pre-frame bypass, then sof bypass
        tbl[0]  = '{1'b0, 8'h3C, 3'd2, 1'b1, 1'b0, 8'h3C};
        tbl[1]  = '{1'b1, 8'h5A, 3'd0, 1'b0, 1'b0, 8'h5A};
        // keys 11,22,33,44: num_keys=3 wraps at index 2
        tbl[2]  = '{1'b1, 8'h00, 3'd3, 1'b0, 1'b0, 8'h11};
        tbl[3]  = '{1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 8'h22};
        tbl[4]  = '{1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 8'h33};
        tbl[5]  = '{1'b0, 8'h00, 3'd3, 1'b0, 1'b0, 8'h11};
        // num_keys=7 clamps to 4; mid-frame cfg change is ignored (vec 7)
        tbl[6]  = '{1'b1, 8'hFF, 3'd7, 1'b0, 1'b0, 8'hEE};
        tbl[7]  = '{1'b0, 8'hFF, 3'd0, 1'b1, 1'b1, 8'hDD};
        tbl[8]  = '{1'b0, 8'hFF, 3'd7, 1'b0, 1'b0, 8'hCC};
        tbl[9]  = '{1'b0, 8'hFF, 3'd7, 1'b0, 1'b0, 8'hBB};
        tbl[10] = '{1'b0, 8'hFF, 3'd7, 1'b0, 1'b0, 8'hEE};
        // num_keys=1: index stays at 0 (sof right after a wrap)
        tbl[11] = '{1'b1, 8'h00, 3'd1, 1'b0, 1'b0, 8'h11};
        tbl[12] = '{1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 8'h11};
        // keys 01,02: chained encrypt
        tbl[13] = '{1'b1, 8'h10, 3'd2, 1'b1, 1'b0, 8'h11};
        tbl[14] = '{1'b0, 8'h20, 3'd2, 1'b1, 1'b0, 8'h33};
        tbl[15] = '{1'b0, 8'h30, 3'd2, 1'b1, 1'b0, 8'h02};
        // chained decrypt of the above
        tbl[16] = '{1'b1, 8'h11, 3'd2, 1'b1, 1'b1, 8'h10};
        tbl[17] = '{1'b0, 8'h33, 3'd2, 1'b1, 1'b1, 8'h20};
        tbl[18] = '{1'b0, 8'h02, 3'd2, 1'b1, 1'b1, 8'h30};

        // reset, then idle
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst dout", dout, 8'h00);
        chk("rst in_ready", {7'd0, in_ready}, 8'd1);

        for (int i = 0; i < 2; i++) apply(i);
        load_key(2'd0, 8'h11);
        load_key(2'd1, 8'h22);
        load_key(2'd2, 8'h33);
        load_key(2'd3, 8'h44);
        for (int i = 2; i < 13; i++) apply(i);
        load_key(2'd0, 8'h01);
        load_key(2'd1, 8'h02);
        for (int i = 13; i < 19; i++) apply(i);

        // drain
        in_valid = 1'b0;
        tick();
        chk("drain out_valid", {7'd0, out_valid}, 8'd0);

        // backpressure: one word captured, then held for 3 cycles
        num_keys = 3'd2; mode = 1'b0; dir = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_sof = 1'b1; din = 8'h40;
        tick();
        chk("bp first dout", dout, 8'h41);
        in_sof = 1'b0; din = 8'h50;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp%0d in_ready", c), {7'd0, in_ready}, 8'd0);
            tick();
            chk($sformatf("bp%0d out_valid", c), {7'd0, out_valid}, 8'd1);
            chk($sformatf("bp%0d dout", c), dout, 8'h41);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", {7'd0, in_ready}, 8'd1);
        tick();
        chk("bp w1 dout", dout, 8'h52);
        din = 8'h60;
        tick();
        chk("bp w2 dout", dout, 8'h61);
        din = 8'h70;
        tick();
        chk("bp w3 dout", dout, 8'h72);
        chk("bp w3 out_valid", {7'd0, out_valid}, 8'd1);

        // key write mid-frame while a word waits
        in_sof = 1'b1; din = 8'h00;
        tick();
        chk("kset w0 dout", dout, 8'h01);
        in_sof = 1'b0; kset = 1'b1; kaddr = 2'd1; kdata = 8'hA0;
        #1;
        chk("kset in_ready", {7'd0, in_ready}, 8'd0);
        tick();
        chk("kset stall out_valid", {7'd0, out_valid}, 8'd0);
        kset = 1'b0;
        tick();
        chk("kset new key dout", dout, 8'hA0);
        chk("kset new key out_valid", {7'd0, out_valid}, 8'd1);

        // async reset between edges
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async rst out_valid", {7'd0, out_valid}, 8'd0);
        chk("async rst dout", dout, 8'h00);
        #1;
        reset = 1'b0;
        tick();
        // key table lost: keys are zero after reset
        in_valid = 1'b1; out_ready = 1'b1; in_sof = 1'b1; din = 8'h77;
        num_keys = 3'd2; mode = 1'b0;
        tick();
        chk("post rst dout", dout, 8'h77);
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dea_stream.md
# dea_stream

Parametrised streaming XOR cipher engine, the next generation of the DEA byte cipher. It holds a programmable table of up to MAX_KEYS keys of DATA_W bits and applies them round-robin to an input stream. It adds a valid/ready handshake on both sides, frame restart, bypass and chained (feedback) modes in both directions. It sits between the host byte source and the output sink on the dclk domain.

## Interface
- DATA_W, 8, width of data words and keys
- MAX_KEYS, 4, key table depth (≥1); KW = clog2(MAX_KEYS), min 1, is derived locally
- dclk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- kset  in  1  key write strobe; while high the data input is stalled
- kaddr  in  KW  key table index to write
- kdata  in  DATA_W  key value to write
- num_keys  in  KW+1  active key count, sampled at frame start
- mode  in  1  0 = rolling XOR, 1 = chained; sampled at frame start
- dir  in  1  chained only: 0 = encrypt, 1 = decrypt; sampled at frame start
- in_valid  in  1  input word valid
- in_sof  in  1  qualifies the current input word as first of a frame
- din  in  DATA_W  input word
- in_ready  out  1  engine accepts din this cycle
- out_valid  out  1  dout holds a result
- dout  out  DATA_W  result word
- out_ready  in  1  sink consumes dout this cycle

## Operation
- Key table: on kset=1 at an edge, key[kaddr] <= kdata. If kaddr ≥ MAX_KEYS, the write is ignored. A write takes effect for the next accepted word.
- Accept: acc = in_valid & in_ready; in_ready = !kset & (!out_valid | out_ready). This is combinational and never depends on in_valid.
- Frame start (acc & in_sof):
  - latch cfg_n = min(num_keys, MAX_KEYS), cfg_mode = mode, cfg_dir = dir;
  - this word uses key index 0 and chain value 0;
  - the new cfg applies to this word.
- Key index idx: after each accepted word, idx <= (idx == cfg_n-1) ? 0 : idx+1. It wraps at cfg_n-1 and never reaches cfg_n.
- Result per accepted word, with k = key[idx] and c = chain register:
  - cfg_n == 0: dout = din (bypass); idx and chain unchanged;
  - mode 0: dout = din ^ k;
  - mode 1, dir 0: dout = din ^ k ^ c; then c <= dout;
  - mode 1, dir 1: dout = din ^ k ^ c; then c <= din.
  - Encrypt and decrypt with the same keys and cfg are exact inverses.
- Words accepted before any frame start use the reset cfg (cfg_n=0, i.e. bypass).
- Changes on num_keys, mode and dir mid-frame have no effect until the next frame start.
- All arithmetic is modulo width. No saturation except the cfg_n clamp.

## Timing
- Reset (async, immediate):
  - out_valid=0, dout=0;
  - idx=0, c=0, cfg_n=0, cfg_mode=0, cfg_dir=0;
  - every key = 0.
  - in_ready follows its equation, so it is 1 whenever kset=0.
- Latency: a word accepted at edge N appears on dout with out_valid=1 from edge N until consumed.
- Backpressure: while out_valid & !out_ready, dout and out_valid hold stable and in_ready=0.
- Throughput: with out_ready=1 held high, one word is accepted and one delivered per cycle. A drain and a new accept in the same cycle is legal.
- If kset and an in_valid word arrive in the same cycle, the key write wins and the word waits. The word is later encrypted with the new key.
- Frame start on the word right after a wrap: idx is forced to 0 regardless of its current value.
- cfg_n=1: idx stays at 0.
- Reset asserted mid-frame or mid-stall: any pending output is dropped and the key table is lost. Host must reprogram.

## Test plan
- Reset then idle: out_valid=0, dout=0, in_ready=1.
  - Sof word 0x5A with num_keys=0 → dout=0x5A next cycle.
- Load keys 0x11,0x22,0x33,0x44, num_keys=3, mode=0.
  - Sof stream 0x00,0x00,0x00,0x00 → 0x11,0x22,0x33,0x11 (wrap at 2).
- Same keys, num_keys=7 (clamped to 4).
  - Stream of five 0xFF → 0xEE,0xDD,0xCC,0xBB,0xEE.
- Chained encrypt: keys 0x01,0x02, num_keys=2, mode=1, dir=0.
  - Sof 0x10,0x20,0x30 → 0x11,0x33,0x02.
  - Feed those outputs with dir=1 under a new sof → 0x10,0x20,0x30.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1.
  - Exactly one word is captured, dout is stable and in_ready=0.
  - Release → throughput returns to 1/cycle with no loss or duplication.
- kset asserted mid-frame, writing key[1]=0xA0 while in_valid=1: in_ready=0 that cycle.
  - The next word at idx 1 uses 0xA0.
  - Async reset pulse between edges clears out_valid immediately.
